// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, ALUOp codes,
// opcodes, PC source selects and the bundled control-output struct.
package mc_pkg;

  localparam int unsigned MC_OP_W    = 6;
  localparam int unsigned MC_ALUOP_W = 3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } mc_state_e;

  // Must stay identical to the codes ALU_Ctrl decodes
  localparam logic [MC_ALUOP_W-1:0] ALUOP_R_TYPE = 3'd0;
  localparam logic [MC_ALUOP_W-1:0] ALUOP_ADDI   = 3'd1;
  localparam logic [MC_ALUOP_W-1:0] ALUOP_SLTIU  = 3'd2;
  localparam logic [MC_ALUOP_W-1:0] ALUOP_BEQ    = 3'd3;
  localparam logic [MC_ALUOP_W-1:0] ALUOP_LUI    = 3'd4;
  localparam logic [MC_ALUOP_W-1:0] ALUOP_ORI    = 3'd5;
  localparam logic [MC_ALUOP_W-1:0] ALUOP_BNE    = 3'd6;

  localparam logic [MC_OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [MC_OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [MC_OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [MC_OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [MC_OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [MC_OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [MC_OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [MC_OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [MC_OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [MC_OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       branch_ne;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_b;
    logic [MC_ALUOP_W-1:0] alu_op;
    logic       illegal;
  } mc_ctrl_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier: ALUOp, B-operand select and instruction class flags.
module mc_op_decode
  import mc_pkg::*;
(
  input  logic [MC_OP_W-1:0]    op,
  output logic [MC_ALUOP_W-1:0] alu_op,
  output logic                  alu_src_b,
  output logic                  is_mem,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  is_rtype,
  output logic                  is_branch,
  output logic                  branch_ne,
  output logic                  is_jump,
  output logic                  illegal
);

  always_comb begin
    alu_op    = ALUOP_R_TYPE;
    alu_src_b = 1'b0;
    is_mem    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_rtype  = 1'b0;
    is_branch = 1'b0;
    branch_ne = 1'b0;
    is_jump   = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_RTYPE: is_rtype = 1'b1;
      OP_ADDI: begin
        alu_op    = ALUOP_ADDI;
        alu_src_b = 1'b1;
      end
      OP_LW: begin
        alu_op    = ALUOP_ADDI;
        alu_src_b = 1'b1;
        is_mem    = 1'b1;
        is_load   = 1'b1;
      end
      OP_SW: begin
        alu_op    = ALUOP_ADDI;
        alu_src_b = 1'b1;
        is_mem    = 1'b1;
        is_store  = 1'b1;
      end
      OP_SLTIU: begin
        alu_op    = ALUOP_SLTIU;
        alu_src_b = 1'b1;
      end
      OP_LUI: begin
        alu_op    = ALUOP_LUI;
        alu_src_b = 1'b1;
      end
      OP_ORI: begin
        alu_op    = ALUOP_ORI;
        alu_src_b = 1'b1;
      end
      OP_BEQ: begin
        alu_op    = ALUOP_BEQ;
        is_branch = 1'b1;
      end
      OP_BNE: begin
        alu_op    = ALUOP_BNE;
        is_branch = 1'b1;
        branch_ne = 1'b1;
      end
      OP_J:    is_jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory ready handshake.
// Optional retired-instruction counter (instret_o) when MC_PERF_CNT_EN is defined.
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned OP_W    = MC_OP_W,
  parameter int unsigned ALUOP_W = MC_ALUOP_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               mem_ready_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               iord_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic [1:0]         pc_src_o,
  output logic               branch_ne_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_b_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               illegal_o,
  output logic [2:0]         state_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]        instret_o
`endif
);

  mc_state_e          state_q, state_d;
  logic [OP_W-1:0]    op_q;
  logic [OP_W-1:0]    dec_op;
  mc_ctrl_t           ctrl_c, ctrl;

  logic [MC_ALUOP_W-1:0] d_alu_op;
  logic d_alu_src_b, d_is_mem, d_is_load, d_is_store, d_is_rtype;
  logic d_is_branch, d_branch_ne, d_is_jump, d_illegal;

  // op_q is still loading during DECODE, so classify the live opcode there
  assign dec_op = (state_q == ST_DECODE) ? instr_op_i : op_q;

  mc_op_decode u_dec (
    .op        (dec_op),
    .alu_op    (d_alu_op),
    .alu_src_b (d_alu_src_b),
    .is_mem    (d_is_mem),
    .is_load   (d_is_load),
    .is_store  (d_is_store),
    .is_rtype  (d_is_rtype),
    .is_branch (d_is_branch),
    .branch_ne (d_branch_ne),
    .is_jump   (d_is_jump),
    .illegal   (d_illegal)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= instr_op_i;
    end
  end

  always_comb begin
    ctrl_c  = '0;
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_req = 1'b1;
        if (mem_ready_i) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = PC_SRC_PC4;
          state_d         = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (d_illegal) begin
          ctrl_c.illegal = 1'b1;
          state_d        = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ctrl_c.alu_op    = d_alu_op;
        ctrl_c.alu_src_b = d_alu_src_b;
        if (d_is_branch) begin
          ctrl_c.pc_write_cond = 1'b1;
          ctrl_c.pc_src        = PC_SRC_BRANCH;
          ctrl_c.branch_ne     = d_branch_ne;
          state_d              = ST_FETCH;
        end else if (d_is_jump) begin
          ctrl_c.pc_write = 1'b1;
          ctrl_c.pc_src   = PC_SRC_JUMP;
          state_d         = ST_FETCH;
        end else if (d_is_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.iord    = 1'b1;
        ctrl_c.mem_we  = d_is_store;
        if (mem_ready_i) state_d = d_is_store ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.reg_dst    = d_is_rtype;
        ctrl_c.mem_to_reg = d_is_load;
        ctrl_c.alu_op     = d_alu_op;
        ctrl_c.alu_src_b  = d_alu_src_b;
        state_d           = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset forces every output low at once, aborting any in-flight memory access
  assign ctrl = rst_i ? ctrl_c : '0;

  assign mem_req_o       = ctrl.mem_req;
  assign mem_we_o        = ctrl.mem_we;
  assign iord_o          = ctrl.iord;
  assign ir_write_o      = ctrl.ir_write;
  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign pc_src_o        = ctrl.pc_src;
  assign branch_ne_o     = ctrl.branch_ne;
  assign reg_write_o     = ctrl.reg_write;
  assign reg_dst_o       = ctrl.reg_dst;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign ALUOp_o         = ctrl.alu_op;
  assign illegal_o       = ctrl.illegal;
  assign state_o         = state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instret_q <= '0;
    end else if (state_d == ST_FETCH &&
                 (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB)) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret_o = instret_q;
`endif

endmodule
